// File: rtl/reflet_mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM states and owner encoding.
package reflet_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StTurn0 = 3'd1,
        StTurn1 = 3'd2,
        StOwn0  = 3'd3,
        StOwn1  = 3'd4
    } arb_state_e;

    localparam logic OwnM0 = 1'b0;
    localparam logic OwnM1 = 1'b1;

    function automatic arb_state_e turn_of(input logic master);
        return master ? StTurn1 : StTurn0;
    endfunction

endpackage

// File: rtl/reflet_mem_arbiter_if.sv
// One master's view of the shared memory port: request/address/data in, run enable and read data out.
interface reflet_mem_arbiter_if #(
    parameter int unsigned WORDSIZE = 8
) ();

    logic                req;
    logic [WORDSIZE-1:0] addr;
    logic [WORDSIZE-1:0] wdata;
    logic                we;
    logic                enable;
    logic [WORDSIZE-1:0] rdata;

    modport master (output req, addr, wdata, we, input enable, rdata);
    modport slave  (input req, addr, wdata, we, output enable, rdata);

endinterface

// File: rtl/reflet_arb_quantum.sv
// Time-quantum counter: cleared on handover, counts owned cycles and saturates at QUANTUM-1.
module reflet_arb_quantum #(
    parameter int unsigned QUANTUM = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic incr_i,
    output logic expired_o
);

    localparam int unsigned     CntW   = $clog2(QUANTUM + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(QUANTUM - 1);

    logic [CntW-1:0] qcnt_d, qcnt_q;

    always_comb begin
        qcnt_d = qcnt_q;
        if (clear_i) begin
            qcnt_d = '0;
        end else if (incr_i && (qcnt_q != CntMax)) begin
            qcnt_d = qcnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end

    assign expired_o = (qcnt_q == CntMax);

endmodule

// File: rtl/reflet_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between two stall-by-enable masters.
// A turnaround cycle routes the new owner's address early so its first enabled cycle sees data.
module reflet_mem_arbiter
    import reflet_mem_arbiter_pkg::*;
#(
    parameter int unsigned WORDSIZE = 8,
    parameter int unsigned QUANTUM  = 8
) (
    input  logic                clk,
    input  logic                reset,
    reflet_mem_arbiter_if.slave m0,
    reflet_mem_arbiter_if.slave m1,
    output logic [WORDSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata,
    output logic                mem_we,
    input  logic [WORDSIZE-1:0] mem_rdata,
    output logic                owner
);

    arb_state_e state_q;
    logic       owner_q;
    logic       last_q;
    logic       expired;
    logic       own0, own1;

    assign own0 = (state_q == StOwn0);
    assign own1 = (state_q == StOwn1);

    reflet_arb_quantum #(
        .QUANTUM (QUANTUM)
    ) u_quantum (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!(own0 || own1)),
        .incr_i    (own0 || own1),
        .expired_o (expired)
    );

    // owner switches on entry to TURNx so the turnaround cycle already presents mx's address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= OwnM0;
            last_q  <= OwnM1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (m0.req && m1.req) begin
                        state_q <= turn_of(!last_q);
                        owner_q <= !last_q;
                    end else if (m0.req) begin
                        state_q <= StTurn0;
                        owner_q <= OwnM0;
                    end else if (m1.req) begin
                        state_q <= StTurn1;
                        owner_q <= OwnM1;
                    end
                end
                StTurn0: state_q <= StOwn0;
                StTurn1: state_q <= StOwn1;
                StOwn0: begin
                    if (!m0.req || (m1.req && expired)) begin
                        last_q <= OwnM0;
                        if (m1.req) begin
                            state_q <= StTurn1;
                            owner_q <= OwnM1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StOwn1: begin
                    if (!m1.req || (m0.req && expired)) begin
                        last_q <= OwnM1;
                        if (m0.req) begin
                            state_q <= StTurn0;
                            owner_q <= OwnM0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign owner     = owner_q;
    assign mem_addr  = owner_q ? m1.addr  : m0.addr;
    assign mem_wdata = owner_q ? m1.wdata : m0.wdata;
    assign mem_we    = !reset && ((own0 && m0.req && m0.we) || (own1 && m1.req && m1.we));

    assign m0.enable = own0 && !reset;
    assign m1.enable = own1 && !reset;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

endmodule
